module_rx_buffer_spi: RTL and testbench

- Receive-side buffer directly downstream of the SPI master; consumes the master's received-byte write strobe, write address and received data.
- Stores bytes in an internal synchronous RAM and tracks transaction status (busy, done, count, overflow).
- Exposes a registered read port and status to the processor-side register interface.
- Single clock domain, shared with the SPI master.

---
 rtl/module_rx_buffer_spi.sv | 123 ++++++++++++
 tb/tb_module_rx_buffer_spi.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/module_rx_buffer_spi.sv
// SPI receive buffer: byte RAM, registered read port,
// receive counter and transaction status FSM.
module module_rx_buffer_spi #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_ram2_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] dato_recibido_i,
  input  logic              proccess_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W:0]   rx_count_o,
  output logic [ADDR_W-1:0] last_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              irq_o,
  output logic              ovf_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX =
    {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t state;
  state_t state_nxt;
  logic   irq_nxt;

  // RAM array is not reset
  always_ff @(posedge clk_i) begin
    if (we_ram2_i) begin
      mem[addr2_i] <= dato_recibido_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rd_data_o <= mem[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_count_o  <= '0;
      ovf_o       <= 1'b0;
      last_addr_o <= '0;
    end else begin
      if (we_ram2_i) begin
        last_addr_o <= addr2_i;
      end
      // clear wins, then a coincident write counts
      if (clr_i) begin
        rx_count_o <= {{ADDR_W{1'b0}}, we_ram2_i};
        ovf_o      <= 1'b0;
      end else if (we_ram2_i) begin
        if (rx_count_o == CNT_MAX) begin
          ovf_o <= 1'b1;
        end else begin
          rx_count_o <= rx_count_o + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      irq_o <= 1'b0;
    end else begin
      state <= state_nxt;
      irq_o <= irq_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (proccess_i) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!proccess_i) begin
          state_nxt = DONE;
          irq_nxt   = 1'b1;
        end
      end
      DONE: begin
        if (proccess_i) begin
          state_nxt = BUSY;
        end else if (clr_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == BUSY);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_module_rx_buffer_spi.sv
// Bench for module_rx_buffer_spi: directed scenarios plus
// random traffic against a behavioural model.
module tb_module_rx_buffer_spi;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          we_ram2_i = 1'b0;
  logic [AW-1:0] addr2_i = '0;
  logic [DW-1:0] dato_recibido_i = '0;
  logic          proccess_i = 1'b0;
  logic          rd_en_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          clr_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic [AW:0]   rx_count_o;
  logic [AW-1:0] last_addr_o;
  logic          busy_o;
  logic          done_o;
  logic          irq_o;
  logic          ovf_o;

  module_rx_buffer_spi #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .we_ram2_i       (we_ram2_i),
    .addr2_i         (addr2_i),
    .dato_recibido_i (dato_recibido_i),
    .proccess_i      (proccess_i),
    .rd_en_i         (rd_en_i),
    .rd_addr_i       (rd_addr_i),
    .clr_i           (clr_i),
    .rd_data_o       (rd_data_o),
    .rd_valid_o      (rd_valid_o),
    .rx_count_o      (rx_count_o),
    .last_addr_o     (last_addr_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .irq_o           (irq_o),
    .ovf_o           (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  // behavioural model
  int      m_mem [DEPTH];
  bit      m_wr [DEPTH];
  int      m_cnt;
  bit      m_ovf;
  int      m_last;
  int      m_rdata;
  bit      m_rvalid;
  bit      m_irq;
  bit      m_in_txn;
  bit      m_finished;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic m_reset();
    m_cnt = 0; m_ovf = 0; m_last = 0;
    m_rdata = 0; m_rvalid = 0; m_irq = 0;
    m_in_txn = 0; m_finished = 0;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".rvalid"}, 32'(rd_valid_o), 32'(m_rvalid));
    check({pfx, ".rdata"}, 32'(rd_data_o), m_rdata);
    check({pfx, ".count"}, 32'(rx_count_o), m_cnt);
    check({pfx, ".last"}, 32'(last_addr_o), m_last);
    check({pfx, ".busy"}, 32'(busy_o), 32'(m_in_txn));
    check({pfx, ".done"}, 32'(done_o), 32'(m_finished));
    check({pfx, ".irq"}, 32'(irq_o), 32'(m_irq));
    check({pfx, ".ovf"}, 32'(ovf_o), 32'(m_ovf));
  endtask

  // apply inputs, update the model at the edge, then compare
  task automatic cyc(input string pfx,
                     input bit we, input int a, input int d,
                     input bit p, input bit re, input int ra,
                     input bit c);
    we_ram2_i = we;
    addr2_i = AW'(a);
    dato_recibido_i = DW'(d);
    proccess_i = p;
    rd_en_i = re;
    rd_addr_i = AW'(ra);
    clr_i = c;
    @(posedge clk_i);
    m_rvalid = re;
    if (re) m_rdata = m_mem[ra];
    if (we) begin
      m_mem[a] = d;
      m_wr[a] = 1;
      m_last = a;
    end
    if (c) begin
      m_cnt = we ? 1 : 0;
      m_ovf = 0;
    end else if (we) begin
      if (m_cnt == DEPTH) m_ovf = 1;
      else m_cnt++;
    end
    m_irq = 0;
    if (m_in_txn && !p) begin
      m_in_txn = 0; m_finished = 1; m_irq = 1;
    end else if (!m_in_txn && p) begin
      m_in_txn = 1; m_finished = 0;
    end else if (m_finished && c) begin
      m_finished = 0;
    end
    #1;
    check_all(pfx);
  endtask

  task automatic all_zero(input string pfx);
    check({pfx, ".rvalid"}, 32'(rd_valid_o), 0);
    check({pfx, ".rdata"}, 32'(rd_data_o), 0);
    check({pfx, ".count"}, 32'(rx_count_o), 0);
    check({pfx, ".last"}, 32'(last_addr_o), 0);
    check({pfx, ".busy"}, 32'(busy_o), 0);
    check({pfx, ".done"}, 32'(done_o), 0);
    check({pfx, ".irq"}, 32'(irq_o), 0);
    check({pfx, ".ovf"}, 32'(ovf_o), 0);
  endtask

  initial begin
    int p_run;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0; m_wr[i] = 0;
    end
    m_reset();
    #2 rst_i = 1'b0;
    #1 all_zero("rst_async");
    repeat (2) @(posedge clk_i);
    #1 all_zero("rst_hold");
    rst_i = 1'b1;

    // three-byte transaction
    cyc("t_start", 0, 0, 0, 1, 0, 0, 0);
    check("t_busy", 32'(busy_o), 1);
    cyc("t_w0", 1, 0, 'hA5, 1, 0, 0, 0);
    cyc("t_w1", 1, 1, 'h3C, 1, 0, 0, 0);
    cyc("t_w2", 1, 2, 'hFF, 1, 0, 0, 0);
    cyc("t_end", 0, 0, 0, 0, 0, 0, 0);
    check("t_irq", 32'(irq_o), 1);
    check("t_done", 32'(done_o), 1);
    check("t_cnt", 32'(rx_count_o), 3);
    check("t_last", 32'(last_addr_o), 2);
    cyc("t_post", 0, 0, 0, 0, 0, 0, 0);
    check("t_irq_once", 32'(irq_o), 0);
    cyc("t_r0", 0, 0, 0, 0, 1, 0, 0);
    check("t_rd0", 32'(rd_data_o), 'hA5);
    cyc("t_r1", 0, 0, 0, 0, 1, 1, 0);
    check("t_rd1", 32'(rd_data_o), 'h3C);
    cyc("t_r2", 0, 0, 0, 0, 1, 2, 0);
    check("t_rd2", 32'(rd_data_o), 'hFF);
    cyc("t_ridle", 0, 0, 0, 0, 0, 0, 0);

    // read/write collision returns old data
    cyc("c_w", 1, 5, 'h11, 0, 0, 0, 0);
    cyc("c_rw", 1, 5, 'h22, 0, 1, 5, 0);
    check("c_old", 32'(rd_data_o), 'h11);
    cyc("c_r", 0, 0, 0, 0, 1, 5, 0);
    check("c_new", 32'(rd_data_o), 'h22);

    // saturation and overflow
    cyc("s_clr", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i <= DEPTH; i++)
      cyc("s_w", 1, i % DEPTH, 16 * i + 1, 0, 0, 0, 0);
    check("s_cnt", 32'(rx_count_o), DEPTH);
    check("s_ovf", 32'(ovf_o), 1);
    cyc("s_clr2", 0, 0, 0, 0, 0, 0, 1);
    check("s_cnt0", 32'(rx_count_o), 0);
    check("s_ovf0", 32'(ovf_o), 0);
    check("s_done0", 32'(done_o), 0);

    // clear together with a write
    cyc("cw", 1, 3, 'h77, 0, 0, 0, 1);
    check("cw_cnt", 32'(rx_count_o), 1);

    // minimum transaction then re-entry from DONE
    cyc("m_p", 0, 0, 0, 1, 0, 0, 0);
    cyc("m_e", 0, 0, 0, 0, 0, 0, 0);
    check("m_irq", 32'(irq_o), 1);
    cyc("m_re", 0, 0, 0, 1, 0, 0, 0);
    check("m_re_busy", 32'(busy_o), 1);
    check("m_re_done", 32'(done_o), 0);
    check("m_re_irq", 32'(irq_o), 0);
    cyc("m_w", 1, 4, 'h5A, 1, 0, 0, 0);

    // asynchronous reset mid-write, mid-transaction
    we_ram2_i = 1'b1; addr2_i = 3'd6;
    dato_recibido_i = 8'h99; proccess_i = 1'b1;
    #3 rst_i = 1'b0;
    #1 all_zero("r_mid");
    m_reset();
    we_ram2_i = 1'b0; proccess_i = 1'b0;
    @(posedge clk_i);
    #1 all_zero("r_hold");
    rst_i = 1'b1;
    cyc("r_after", 0, 0, 0, 0, 0, 0, 0);
    check("r_no_irq", 32'(irq_o), 0);
    cyc("r_rd", 0, 0, 0, 0, 1, 4, 0);
    check("r_ram_kept", 32'(rd_data_o), 'h5A);

    // random traffic
    p_run = 0;
    for (int n = 0; n < 600; n++) begin
      bit we, re, c;
      int a, ra, d;
      we = ($urandom_range(0, 2) != 0);
      a = $urandom_range(0, DEPTH - 1);
      d = $urandom_range(0, 255);
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) p_run = 1 - p_run;
      ra = $urandom_range(0, DEPTH - 1);
      re = ($urandom_range(0, 1) == 1) && m_wr[ra];
      cyc("rnd", we, a, d, p_run[0], re, ra, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
